// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, ALUOp and state/class encodings for the RV32-subset
// multi-cycle control path.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;
    localparam logic [1:0] ALUOP_LUI = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LUI = 3'd2,
        CLS_LW  = 3'd3,
        CLS_SW  = 3'd4,
        CLS_BR  = 3'd5
    } op_class_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle: opcode, flags, ready handshakes
// and the decoded control set.
interface multicycle_controller_if;

    logic [6:0] Opcode;
    logic       Zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       InstrReq;
    logic       IRWrite;
    logic       PCWrite;
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;

    modport master (
        input  Opcode, Zero, imem_ready, dmem_ready,
        output InstrReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch
    );

    modport slave (
        output Opcode, Zero, imem_ready, dmem_ready,
        input  InstrReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, ALUOp, Branch
    );

endinterface

// File: rtl/multicycle_controller_opcode_class_decode.sv
// Maps a 7-bit opcode to its instruction class and a legal flag.
module opcode_class_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CLS_R;
        legal    = '1;
        case (op)
            OP_R:    op_class = CLS_R;
            OP_I:    op_class = CLS_I;
            OP_LUI:  op_class = CLS_LUI;
            OP_LW:   op_class = CLS_LW;
            OP_SW:   op_class = CLS_SW;
            OP_BR:   op_class = CLS_BR;
            default: legal    = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// timeouts, sticky trap and a retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus,
    output logic                    trap,
    output logic                    retire,
    output logic [CNT_W-1:0]        retired_cnt
);

    state_t     state, state_nxt;
    logic [6:0] op_q;
    logic [6:0] dec_op;
    logic [7:0] wait_cnt;
    op_class_t  op_class;
    logic       legal;
    logic       timeout;

    logic       instr_req, ir_write, pc_write, alu_src, mem_to_reg;
    logic       reg_write, mem_read, mem_write, branch, trap_c, retire_c;
    logic [1:0] alu_op;

    // DECODE classifies the live opcode so an illegal one traps next cycle;
    // later states use the latched copy.
    assign dec_op  = (state == DECODE) ? bus.Opcode : op_q;
    assign timeout = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    opcode_class_decode u_decode (
        .op       (dec_op),
        .op_class (op_class),
        .legal    (legal)
    );

    always_comb begin
        state_nxt  = state;
        instr_req  = '0;
        ir_write   = '0;
        pc_write   = '0;
        alu_src    = '0;
        mem_to_reg = '0;
        reg_write  = '0;
        mem_read   = '0;
        mem_write  = '0;
        alu_op     = ALUOP_MEM;
        branch     = '0;
        trap_c     = '0;
        retire_c   = '0;
        case (state)
            FETCH: begin
                instr_req = '1;
                if (bus.imem_ready) begin
                    ir_write  = '1;
                    pc_write  = '1;
                    state_nxt = DECODE;
                end else if (timeout) begin
                    state_nxt = TRAP;
                end
            end
            DECODE: state_nxt = legal ? EXEC : TRAP;
            EXEC: begin
                case (op_class)
                    CLS_R:   begin alu_op = ALUOP_RI;                 state_nxt = WB;  end
                    CLS_I:   begin alu_op = ALUOP_RI;  alu_src = '1;  state_nxt = WB;  end
                    CLS_LUI: begin alu_op = ALUOP_LUI; alu_src = '1;  state_nxt = WB;  end
                    CLS_LW,
                    CLS_SW:  begin alu_op = ALUOP_MEM; alu_src = '1;  state_nxt = MEM; end
                    default: begin
                        alu_op    = ALUOP_BR;
                        branch    = bus.Zero;
                        retire_c  = '1;
                        state_nxt = FETCH;
                    end
                endcase
            end
            MEM: begin
                alu_src   = '1;
                mem_read  = (op_class == CLS_LW);
                mem_write = (op_class == CLS_SW);
                if (bus.dmem_ready) begin
                    retire_c  = (op_class == CLS_SW);
                    state_nxt = (op_class == CLS_SW) ? FETCH : WB;
                end else if (timeout) begin
                    state_nxt = TRAP;
                end
            end
            WB: begin
                reg_write  = '1;
                mem_to_reg = (op_class == CLS_LW);
                retire_c   = '1;
                state_nxt  = FETCH;
                case (op_class)
                    CLS_R:   alu_op = ALUOP_RI;
                    CLS_I:   begin alu_op = ALUOP_RI;  alu_src = '1; end
                    CLS_LUI: begin alu_op = ALUOP_LUI; alu_src = '1; end
                    default: ;
                endcase
            end
            TRAP:    trap_c    = '1;
            default: state_nxt = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                op_q <= bus.Opcode;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if ((state == FETCH && !bus.imem_ready) || (state == MEM && !bus.dmem_ready))
                wait_cnt <= wait_cnt + 8'd1;
            if (retire_c)
                retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // Outputs are forced low for the whole time reset is held.
    assign bus.InstrReq = rst_n & instr_req;
    assign bus.IRWrite  = rst_n & ir_write;
    assign bus.PCWrite  = rst_n & pc_write;
    assign bus.ALUSrc   = rst_n & alu_src;
    assign bus.MemtoReg = rst_n & mem_to_reg;
    assign bus.RegWrite = rst_n & reg_write;
    assign bus.MemRead  = rst_n & mem_read;
    assign bus.MemWrite = rst_n & mem_write;
    assign bus.ALUOp    = {2{rst_n}} & alu_op;
    assign bus.Branch   = rst_n & branch;
    assign trap         = rst_n & trap_c;
    assign retire       = rst_n & retire_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: expected per-cycle control
// vectors are queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam int unsigned CNT_W = 2;

    // {InstrReq,IRWrite,PCWrite,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp,Branch,trap,retire}
    localparam logic [12:0] IREQ = 13'h1000;
    localparam logic [12:0] IRW  = 13'h0800;
    localparam logic [12:0] PCW  = 13'h0400;
    localparam logic [12:0] SRC  = 13'h0200;
    localparam logic [12:0] M2R  = 13'h0100;
    localparam logic [12:0] RW   = 13'h0080;
    localparam logic [12:0] MR   = 13'h0040;
    localparam logic [12:0] MW   = 13'h0020;
    localparam logic [12:0] A01  = 13'h0008;
    localparam logic [12:0] A10  = 13'h0010;
    localparam logic [12:0] A11  = 13'h0018;
    localparam logic [12:0] BR   = 13'h0004;
    localparam logic [12:0] TRP  = 13'h0002;
    localparam logic [12:0] RET  = 13'h0001;
    localparam logic [12:0] FGO  = IREQ | IRW | PCW;
    localparam logic [12:0] FW   = IREQ;
    localparam logic [12:0] NONE = 13'h0000;

    logic             clk;
    logic             rst_n;
    logic             trap;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic [12:0]      act;

    logic [12:0]      exp_q[$];
    string            tag_q[$];
    int unsigned      errors;
    int unsigned      checks;

    multicycle_controller_if bus_if ();

    multicycle_controller #(
        .MEM_TIMEOUT (16),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if.master),
        .trap        (trap),
        .retire      (retire),
        .retired_cnt (retired_cnt)
    );

    assign act = {bus_if.InstrReq, bus_if.IRWrite, bus_if.PCWrite, bus_if.ALUSrc,
                  bus_if.MemtoReg, bus_if.RegWrite, bus_if.MemRead, bus_if.MemWrite,
                  bus_if.ALUOp, bus_if.Branch, trap, retire};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [12:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(act), 32'(e));
        end
    end

    // One clock cycle of stimulus plus the control vector expected for it.
    task automatic cyc(input logic r, input logic [6:0] op, input logic z,
                       input logic ir, input logic dr, input logic [12:0] e, input string t);
        @(posedge clk);
        #1;
        rst_n             = r;
        bus_if.Opcode     = op;
        bus_if.Zero       = z;
        bus_if.imem_ready = ir;
        bus_if.dmem_ready = dr;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check_cnt(input string tag, input int unsigned want);
        @(negedge clk);
        #1;
        check(tag, 32'(retired_cnt), want);
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        rst_n             = 1'b0;
        bus_if.Opcode     = '0;
        bus_if.Zero       = 1'b0;
        bus_if.imem_ready = 1'b0;
        bus_if.dmem_ready = 1'b0;

        cyc(0, OP_R, 0, 1, 1, NONE, "reset0");
        cyc(0, OP_R, 0, 1, 1, NONE, "reset1");
        check_cnt("cnt_reset", 0);

        // R-type with both readies high
        cyc(1, OP_R, 0, 1, 1, FGO,            "r_fetch");
        cyc(1, OP_R, 0, 1, 1, NONE,           "r_decode");
        cyc(1, OP_R, 0, 1, 1, A10,            "r_exec");
        cyc(1, OP_R, 0, 1, 1, A10 | RW | RET, "r_wb");
        cyc(1, OP_R, 0, 0, 1, FW,             "r_next");
        check_cnt("cnt_r", 1);

        // I-type and LUI
        cyc(1, OP_I,   0, 1, 1, FGO,                  "i_fetch");
        cyc(1, OP_I,   0, 1, 1, NONE,                 "i_decode");
        cyc(1, OP_I,   0, 1, 1, A10 | SRC,            "i_exec");
        cyc(1, OP_I,   0, 1, 1, A10 | SRC | RW | RET, "i_wb");
        cyc(1, OP_LUI, 0, 1, 1, FGO,                  "lui_fetch");
        cyc(1, OP_LUI, 0, 1, 1, NONE,                 "lui_decode");
        cyc(1, OP_LUI, 0, 1, 1, A11 | SRC,            "lui_exec");
        cyc(1, OP_LUI, 0, 1, 1, A11 | SRC | RW | RET, "lui_wb");

        // LW with three dmem wait cycles; fourth retire wraps the 2-bit count
        cyc(1, OP_LW, 0, 1, 0, FGO,  "lw_fetch");
        cyc(1, OP_LW, 0, 1, 0, NONE, "lw_decode");
        cyc(1, OP_LW, 0, 1, 0, SRC,  "lw_exec");
        for (int i = 0; i < 3; i++)
            cyc(1, OP_LW, 0, 1, 0, SRC | MR, $sformatf("lw_memwait%0d", i));
        cyc(1, OP_LW, 0, 1, 1, SRC | MR,        "lw_memdone");
        cyc(1, OP_LW, 0, 1, 1, RW | M2R | RET,  "lw_wb");
        cyc(1, OP_LW, 0, 0, 1, FW,              "lw_next");
        check_cnt("cnt_wrap", 0);

        // BEQ taken then not taken, from a fresh reset
        cyc(0, OP_BR, 0, 1, 1, NONE, "rst_beq");
        cyc(1, OP_BR, 0, 1, 1, FGO,             "beq1_fetch");
        cyc(1, OP_BR, 0, 1, 1, NONE,            "beq1_decode");
        cyc(1, OP_BR, 1, 1, 1, A01 | BR | RET,  "beq1_exec");
        cyc(1, OP_BR, 1, 1, 1, FGO,             "beq2_fetch");
        cyc(1, OP_BR, 1, 1, 1, NONE,            "beq2_decode");
        cyc(1, OP_BR, 0, 1, 1, A01 | RET,       "beq2_exec");
        cyc(1, OP_BR, 0, 0, 1, FW,              "beq_next");
        check_cnt("cnt_beq", 2);

        // SW with ready high completes in four cycles
        cyc(1, OP_SW, 0, 1, 1, FGO,             "sw_fetch");
        cyc(1, OP_SW, 0, 1, 1, NONE,            "sw_decode");
        cyc(1, OP_SW, 0, 1, 1, SRC,             "sw_exec");
        cyc(1, OP_SW, 0, 1, 1, SRC | MW | RET,  "sw_mem");
        cyc(1, OP_SW, 0, 0, 1, FW,              "sw_next");
        check_cnt("cnt_sw", 3);

        // SW aborted by reset during MEM
        cyc(1, OP_SW, 0, 1, 0, FGO,      "swab_fetch");
        cyc(1, OP_SW, 0, 1, 0, NONE,     "swab_decode");
        cyc(1, OP_SW, 0, 1, 0, SRC,      "swab_exec");
        cyc(1, OP_SW, 0, 1, 0, SRC | MW, "swab_mem0");
        cyc(1, OP_SW, 0, 1, 0, SRC | MW, "swab_mem1");
        cyc(0, OP_SW, 0, 1, 1, NONE,     "swab_reset");
        check_cnt("cnt_abort", 0);
        cyc(1, OP_R, 0, 1, 1, FGO,            "resume_fetch");
        cyc(1, OP_R, 0, 1, 1, NONE,           "resume_decode");
        cyc(1, OP_R, 0, 1, 1, A10,            "resume_exec");
        cyc(1, OP_R, 0, 1, 1, A10 | RW | RET, "resume_wb");

        // Illegal opcode traps and holds until reset
        cyc(1, 7'h7f, 0, 1, 1, FGO,  "ill_fetch");
        cyc(1, 7'h7f, 0, 1, 1, NONE, "ill_decode");
        for (int i = 0; i < 21; i++)
            cyc(1, OP_R, 1'(i), 1'(i), 1'(i + 1), TRP, $sformatf("trap_hold%0d", i));
        cyc(0, OP_R, 0, 1, 1, NONE, "trap_clear");

        // imem timeout: 16 waiting FETCH cycles then TRAP
        for (int i = 0; i < 16; i++)
            cyc(1, OP_R, 0, 0, 1, FW, $sformatf("to_wait%0d", i));
        cyc(1, OP_R, 0, 0, 1, TRP, "to_trap");
        cyc(0, OP_R, 0, 0, 1, NONE, "to_reset");

        // Ready on the last permitted cycle wins over the timeout
        for (int i = 0; i < 15; i++)
            cyc(1, OP_R, 0, 0, 0, FW, $sformatf("late_wait%0d", i));
        cyc(1, OP_R, 0, 1, 0, FGO,            "late_ready");
        cyc(1, OP_R, 0, 0, 0, NONE,           "late_decode");
        cyc(1, OP_R, 0, 0, 0, A10,            "late_exec");
        cyc(1, OP_R, 0, 0, 0, A10 | RW | RET, "late_wb");
        cyc(1, OP_R, 0, 0, 0, FW,             "late_next");
        check_cnt("cnt_late", 1);

        @(negedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle control FSM for the RV32 subset datapath: R-type (add/and), I-type (addi), LUI, LW, SW and BEQ. It sequences a shared ALU and the instruction/data memories over FETCH/DECODE/EXEC/MEM/WB, and drives the standard control set: ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp and Branch. It waits on memory ready handshakes, flags illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max wait cycles in FETCH or MEM before trapping (range 1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  7  IR[6:0]; sampled only in DECODE
Zero  in  1  ALU zero flag; sampled only in EXEC for BEQ
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
InstrReq  out  1  instruction memory read request
IRWrite  out  1  load instruction register
PCWrite  out  1  unconditional PC update (PC+4)
ALUSrc  out  1  0: rs2, 1: immediate
MemtoReg  out  1  0: ALU result, 1: memory data
RegWrite  out  1  register file write enable
MemRead  out  1  data memory read
MemWrite  out  1  data memory write
ALUOp  out  2  00 LW/SW, 01 branch, 10 R/I-type, 11 LUI
Branch  out  1  PC load from branch target (taken BEQ)
trap  out  1  sticky error flag
retire  out  1  one-cycle pulse per completed instruction
retired_cnt  out  CNT_W  retired instruction count

Behaviour:
- Async reset: state=FETCH, op_q=0, wait_cnt=0, retired_cnt=0, trap=0. Every output is 0 while rst_n=0. FETCH starts on the first clock edge after deassertion.
- Outputs decode combinationally from the state register and op_q. Any output not named in a state is 0.
- FETCH: InstrReq=1 and ALUOp=00. When imem_ready=1: IRWrite=1 and PCWrite=1 in that cycle, then go to DECODE.
- DECODE: latch op_q<=Opcode. Legal opcodes 0110011, 0010011, 0110111, 0000011, 0100011 and 1100011 go to EXEC. Any other opcode goes to TRAP.
- EXEC by class:
  - R: ALUOp=10, ALUSrc=0, go to WB.
  - I: ALUOp=10, ALUSrc=1, go to WB.
  - LUI: ALUOp=11, ALUSrc=1, go to WB.
  - LW/SW: ALUOp=00, ALUSrc=1, go to MEM.
  - BEQ: ALUOp=01, ALUSrc=0, Branch=Zero, retire=1, go to FETCH.
- MEM: ALUOp=00, ALUSrc=1. MemRead=1 (LW) or MemWrite=1 (SW) is held until dmem_ready=1. On ready, SW asserts retire and goes to FETCH; LW goes to WB.
- WB: RegWrite=1, MemtoReg=(op_q==LW), retire=1, go to FETCH. For R/I/LUI, ALUOp and ALUSrc keep their EXEC values.
- Zero-wait latency: BEQ 3 cycles, R/I/LUI/SW 4 cycles, LW 5 cycles.
- wait_cnt (8 bit):
  - Clears on every state change.
  - Increments each cycle spent in FETCH or MEM while the relevant ready is 0.
  - When wait_cnt==MEM_TIMEOUT-1 and ready is still 0, the next state is TRAP.
  - Ready arriving in that same cycle wins; no trap.
- TRAP: trap=1 and all other control outputs 0. TRAP is absorbing and is left only by reset.
- retired_cnt increments on each retire pulse and wraps from all-ones to 0.
- Ready inputs are ignored outside their own state. A ready already high on entry completes in 1 cycle.
- Reset asserted mid-instruction aborts it immediately: no partial RegWrite or MemWrite, and retired_cnt is not incremented.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode localparams OP_R, OP_I, OP_LUI, OP_LW, OP_SW, OP_BR;
  - ALUOp codes ALUOP_MEM, ALUOP_BR, ALUOP_RI, ALUOP_LUI;
  - state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}.
- One sub-module, opcode_class_decode (combinational). It maps op_q to an instruction class plus a legal flag; the FSM instantiates it once.

Test Plan:
1. Reset, then R-type 0110011 with both readies tied 1 -> RegWrite=1 in cycle 4 only; ALUOp=10 in EXEC/WB; retire=1 once; retired_cnt=1.
2. LW 0000011 with dmem_ready low for 3 MEM cycles -> MemRead held exactly 4 cycles; then WB with RegWrite=1 and MemtoReg=1; total 8 cycles; MemWrite never 1.
3. BEQ 1100011 with Zero=1, then BEQ with Zero=0 -> Branch=1 in the first EXEC and 0 in the second; ALUOp=01; each instruction takes 3 cycles; retired_cnt=2.
4. Opcode 1111111 in DECODE -> next cycle trap=1 with all enables 0. Trap stays 1 through 20 further cycles with readies toggling, and clears only on rst_n=0.
5. imem_ready held 0 with MEM_TIMEOUT=16 -> trap rises after exactly 16 FETCH cycles. Repeat with imem_ready=1 on the 16th cycle -> no trap; DECODE follows.
6. Assert rst_n=0 during the MEM state of an SW -> MemWrite drops immediately; retired_cnt=0; FETCH resumes after deassertion.
